elc_call_scheduler: RTL

- Upstream stage of the elevator controller core.
- Collects floor-call button presses into a pending-call register and picks the next target floor with a SCAN (sweep) policy.
- Drives the controller's one-hot request_floor and consumes its complete and current-floor outputs.
- Times door dwell after each arrival and flags a controller that never arrives.

---
 rtl/elc_pkg.sv | 46 ++++
 rtl/elc_scan_picker.sv | 74 +++++++
 rtl/elc_call_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/elc_pkg.sv
// -----------------------------------------------------------------------------
// elc_pkg
// Shared types, default sizing constants and one-hot helpers for the elevator
// call scheduler. The controller core fixes the floor bus at 8 bits, so the
// helper functions operate on that width.
// -----------------------------------------------------------------------------
package elc_pkg;

  localparam int DEF_FLOORS         = 8;
  localparam int DEF_DWELL_CYCLES   = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 11;
  localparam int IDX_W              = $clog2(DEF_FLOORS);

  typedef logic [DEF_FLOORS-1:0] floor_vec_t;
  typedef logic [IDX_W-1:0]      floor_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT_ARRIVE,
    DWELL
  } state_t;

  // Index of the highest set bit; only meaningful for a one-hot input.
  function automatic floor_idx_t onehot_to_idx(input floor_vec_t v);
    floor_idx_t idx;
    idx = '0;
    for (int i = 0; i < DEF_FLOORS; i++) begin
      if (v[i]) idx = floor_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input floor_vec_t v);
    return (v != '0) && ((v & (v - floor_vec_t'(1))) == '0);
  endfunction

  function automatic floor_vec_t idx_to_onehot(input floor_idx_t idx);
    floor_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/elc_scan_picker.sv
// -----------------------------------------------------------------------------
// elc_scan_picker
// Combinational SCAN target selection. A call at the current floor wins;
// otherwise the nearest call in the sweep direction is taken, and only when
// nothing lies ahead does the picker turn around (flipping the direction).
//
// Ports:
//   pending       in  outstanding call bits, bit i = floor i
//   cur_idx       in  binary index of the current floor
//   sweep_up      in  current sweep direction (1 = up)
//   target        out chosen floor index (cur_idx when nothing else applies)
//   next_sweep_up out direction to adopt if target is dispatched
// -----------------------------------------------------------------------------
module elc_scan_picker
  import elc_pkg::*;
(
  input  logic [DEF_FLOORS-1:0] pending,
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic                  sweep_up,
  output logic [IDX_W-1:0]      target,
  output logic                  next_sweep_up
);

  logic [IDX_W-1:0] lo_above;
  logic [IDX_W-1:0] hi_below;
  logic             has_above;
  logic             has_below;

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    lo_above  = '0;
    hi_below  = '0;
    has_above = 1'b0;
    has_below = 1'b0;
    // Descending scan: the last hit above the current floor is the lowest.
    for (int i = DEF_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(cur_idx))) begin
        lo_above  = floor_idx_t'(i);
        has_above = 1'b1;
      end
    end
    // Ascending scan: the last hit below the current floor is the highest.
    for (int i = 0; i < DEF_FLOORS; i++) begin
      if (pending[i] && (i < int'(cur_idx))) begin
        hi_below  = floor_idx_t'(i);
        has_below = 1'b1;
      end
    end
  end

  always_comb begin
    target        = cur_idx;
    next_sweep_up = sweep_up;
    if (!pending[cur_idx]) begin
      if (sweep_up) begin
        if (has_above) begin
          target = lo_above;
        end else if (has_below) begin
          target        = hi_below;
          next_sweep_up = 1'b0;
        end
      end else begin
        if (has_below) begin
          target = hi_below;
        end else if (has_above) begin
          target        = lo_above;
          next_sweep_up = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elc_call_scheduler.sv
// -----------------------------------------------------------------------------
// elc_call_scheduler
// Upstream stage of the elevator controller core. Latches floor-call button
// presses into a pending register, picks the next target with a SCAN policy,
// hands it to the controller as a one-hot request, times the door dwell after
// each arrival and raises a sticky alarm if the controller never arrives.
//
// Build option: define ELC_FIRE_RECALL_EN to add the fire_recall input, which
// flushes all calls and sends the car to floor 0 with the door held open.
//
// Ports:
//   clk           in  system clock, rising edge
//   reset         in  asynchronous, active-low reset
//   call_btn      in  raw asynchronous button levels, bit i = floor i
//   cur_floor     in  one-hot current floor from the controller
//   complete      in  controller arrived/stopped
//   fire_recall   in  (ELC_FIRE_RECALL_EN only) asynchronous recall level
//   request_floor out one-hot target presented to the controller
//   req_valid     out request_floor holds a live target
//   pending       out registered outstanding calls
//   door_open     out high during dwell
//   sweep_up      out current sweep direction, 1 = up
//   stuck_alarm   out sticky, controller failed to arrive in time
//   floor_err     out sticky, cur_floor not one-hot while selecting a target
// -----------------------------------------------------------------------------
module elc_call_scheduler
  import elc_pkg::*;
#(
  parameter int FLOORS         = DEF_FLOORS,
  parameter int DWELL_CYCLES   = DEF_DWELL_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_btn,
  input  logic [FLOORS-1:0] cur_floor,
  input  logic              complete,
`ifdef ELC_FIRE_RECALL_EN
  input  logic              fire_recall,
`endif
  output logic [FLOORS-1:0] request_floor,
  output logic              req_valid,
  output logic [FLOORS-1:0] pending,
  output logic              door_open,
  output logic              sweep_up,
  output logic              stuck_alarm,
  output logic              floor_err
);

  localparam logic [CNT_W-1:0] DWELL_LOAD   = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // Button capture: two synchronizer flops, a delayed copy for edge detect,
  // and a registered rise pulse that feeds the pending register.
  logic [FLOORS-1:0] btn_meta;
  logic [FLOORS-1:0] btn_sync;
  logic [FLOORS-1:0] btn_prev;
  logic [FLOORS-1:0] rise_q;

  state_t            state,  state_n;
  logic [CNT_W-1:0]  cnt,    cnt_n;
  logic [FLOORS-1:0] request_floor_n;
  logic              req_valid_n;
  logic [FLOORS-1:0] pending_n;
  logic              sweep_up_n;
  logic              stuck_n;
  logic              floor_err_n;

  logic [FLOORS-1:0] set_mask;
  logic [FLOORS-1:0] clr_mask;
  logic              dwell_retrig;

  logic [IDX_W-1:0]  cur_idx;
  logic              cur_ok;
  logic [IDX_W-1:0]  pick_target;
  logic              pick_sweep_up;

`ifdef ELC_FIRE_RECALL_EN
  logic fire_meta;
  logic fire;
  logic recall_q;
  logic recall_n;
`endif

  assign cur_idx   = onehot_to_idx(cur_floor);
  assign cur_ok    = is_onehot(cur_floor);
  assign door_open = (state == DWELL);

  elc_scan_picker u_picker (
    .pending       (pending),
    .cur_idx       (cur_idx),
    .sweep_up      (sweep_up),
    .target        (pick_target),
    .next_sweep_up (pick_sweep_up)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      rise_q   <= '0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge value of its neighbour, as hardware does.
      btn_meta <= call_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      rise_q   <= btn_sync & ~btn_prev;
    end
  end

`ifdef ELC_FIRE_RECALL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_meta <= 1'b0;
      fire      <= 1'b0;
      recall_q  <= 1'b0;
    end else begin
      fire_meta <= fire_recall;
      fire      <= fire_meta;
      recall_q  <= recall_n;
    end
  end
`endif

  // A fresh press of the floor being dwelt at only re-opens the door; it never
  // becomes a call for the floor the car is already standing at.
  assign dwell_retrig = (state == DWELL) && ((rise_q & cur_floor) != '0);

  always_comb begin
    set_mask = rise_q;
    if (state == DWELL) set_mask = rise_q & ~cur_floor;
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    request_floor_n = request_floor;
    req_valid_n     = req_valid;
    sweep_up_n      = sweep_up;
    stuck_n         = stuck_alarm;
    floor_err_n     = floor_err;
    clr_mask        = '0;
`ifdef ELC_FIRE_RECALL_EN
    recall_n        = recall_q;
    if (fire && !recall_q) begin
      // Recall start: abandon whatever trip is underway and head for floor 0.
      request_floor_n = idx_to_onehot(floor_idx_t'(0));
      req_valid_n     = 1'b0;
      cnt_n           = '0;
      state_n         = DISPATCH;
      recall_n        = 1'b1;
    end else if (!fire && recall_q) begin
      request_floor_n = '0;
      req_valid_n     = 1'b0;
      cnt_n           = '0;
      state_n         = IDLE;
      recall_n        = 1'b0;
    end else
`endif
    begin
      unique case (state)
        IDLE: begin
`ifdef ELC_FIRE_RECALL_EN
          // Recall retry after a timeout: keep heading for floor 0.
          if (recall_q) begin
            request_floor_n = idx_to_onehot(floor_idx_t'(0));
            state_n         = DISPATCH;
          end else
`endif
          if (pending != '0) begin
            if (!cur_ok) begin
              floor_err_n = 1'b1;
            end else if (pick_target == cur_idx) begin
              clr_mask = idx_to_onehot(cur_idx);
              cnt_n    = DWELL_LOAD;
              state_n  = DWELL;
            end else begin
              request_floor_n = idx_to_onehot(pick_target);
              sweep_up_n      = pick_sweep_up;
              state_n         = DISPATCH;
            end
          end
        end

        DISPATCH: begin
          req_valid_n = 1'b1;
          cnt_n       = TIMEOUT_LOAD;
          state_n     = WAIT_ARRIVE;
        end

        WAIT_ARRIVE: begin
          if (complete && (cur_floor == request_floor)) begin
            clr_mask        = request_floor;
            req_valid_n     = 1'b0;
            request_floor_n = '0;
            cnt_n           = DWELL_LOAD;
            state_n         = DWELL;
          end else if (cnt <= CNT_ONE) begin
            // The call is kept so the car retries it from IDLE.
            stuck_n         = 1'b1;
            req_valid_n     = 1'b0;
            request_floor_n = '0;
            cnt_n           = '0;
            state_n         = IDLE;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end

        DWELL: begin
`ifdef ELC_FIRE_RECALL_EN
          // Parked at floor 0 under recall: door stays open indefinitely.
          if (recall_q) begin
            cnt_n = cnt;
          end else
`endif
          if (dwell_retrig) begin
            cnt_n = DWELL_LOAD;
          end else if (cnt <= CNT_ONE) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end

        default: state_n = IDLE;
      endcase
    end

    // Clear is applied after set so a simultaneous press of a served floor
    // does not re-arm it.
    pending_n = (pending | set_mask) & ~clr_mask;
`ifdef ELC_FIRE_RECALL_EN
    if (fire) begin
      pending_n  = '0;
      sweep_up_n = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      request_floor <= '0;
      req_valid     <= 1'b0;
      pending       <= '0;
      sweep_up      <= 1'b1;
      stuck_alarm   <= 1'b0;
      floor_err     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      request_floor <= request_floor_n;
      req_valid     <= req_valid_n;
      pending       <= pending_n;
      sweep_up      <= sweep_up_n;
      stuck_alarm   <= stuck_n;
      floor_err     <= floor_err_n;
    end
  end

endmodule
